secure_regfile: RTL and testbench
=================================

# secure_regfile

Parametrised, thread-gated register file: the multi-entry successor to the single secure register. It holds NUM_REGS words that only thread OWNER_TID may read or write, adds per-entry write-lock bits, and adds a saturating access-violation counter with a sticky flag. It sits on the core's register-access port and returns a registered response one cycle after each request.

## Interface
- DATA_WIDTH, 32, word width
- NUM_REGS, 8, number of entries (≥2); AW = $clog2(NUM_REGS)
- TID_WIDTH, 4, thread-id width
- OWNER_TID, 0, only thread permitted access
- CNT_WIDTH, 8, violation counter width
- RESET_VAL, 0, reset value of every entry (DATA_WIDTH bits)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request valid for this cycle
- we  in  1  1 = write, 0 = read (qualified by req)
- lock_set  in  1  lock entry addr (qualified by req)
- addr  in  AW  entry index
- thread_id  in  TID_WIDTH  requesting thread
- wdata  in  DATA_WIDTH  write data
- viol_clr  in  1  clear violation counter and sticky flag
- rdata  out  DATA_WIDTH  read data, valid while ack=1
- ack  out  1  response valid, one-cycle pulse per request
- err  out  1  request denied, valid while ack=1
- viol_count  out  CNT_WIDTH  saturating denied-request count
- viol_sticky  out  1  set on any denial until cleared

## Operation
- No backpressure: a request is accepted every cycle in which req=1; one operation per cycle.
- A request is denied if any of the following holds:
  - thread_id != OWNER_TID;
  - addr >= NUM_REGS (only possible when NUM_REGS is not a power of 2);
  - we=1 and lock[addr]=1.
- Denied request:
  - no entry or lock bit changes;
  - response carries err=1 and rdata=0, for reads and writes alike.
- Granted read: response rdata = entry[addr]; reads of locked entries are allowed.
- Granted write: entry[addr] <= wdata; response rdata=0, err=0.
- lock_set with a granted request: lock[addr] <= 1.
  - If we=1 and the entry was unlocked, the write completes in the same cycle, then the entry is locked.
  - lock_set with we=0 locks without a read side effect; rdata still returns entry[addr].
  - lock_set on an already-locked entry with we=0 is granted (no-op).
- Lock bits clear only on reset; no unlock path exists.
- Violation counter: +1 per denied request, saturating at 2^CNT_WIDTH−1. Any denial sets viol_sticky.
- viol_clr in the same cycle as a denial: the clear applies first, then the count, so viol_count=1 and viol_sticky=1.
- viol_clr is accepted from any thread; it is a debug/status path, not gated.
- req=0: we, lock_set, addr, thread_id and wdata are ignored.

## Timing
- Request in cycle N; ack=1 with err/rdata in cycle N+1. ack is low otherwise.
- Back-to-back requests produce back-to-back acks.
- Storage updates at the edge ending cycle N. A read of the same addr in cycle N+1 returns the new value in N+2.
- viol_count and viol_sticky update at the edge ending the denial cycle, i.e. visible in N+1, aligned with the err response.
- rdata is registered and held at 0 whenever ack=0.
- Reset, asynchronous, may assert mid-transaction:
  - all entries = RESET_VAL; all lock bits = 0;
  - rdata=0, ack=0, err=0, viol_count=0, viol_sticky=0;
  - a request in flight is dropped with no ack.
- First request is accepted in the first clock after rst_n deasserts.

## Test plan
- Reset then read all entries as tid 0, one per cycle → ack every cycle, rdata=0, err=0 throughout, viol_count=0.
- tid 0 writes 0xDEADBEEF to entry 3 in cycle N, reads entry 3 in N+1 → read ack in N+2 with rdata=0xDEADBEEF, err=0.
- tid 5 reads entry 3, then writes 0x1234 to entry 3 → both acks err=1 with rdata=0; entry 3 still 0xDEADBEEF; viol_count=2; viol_sticky=1.
- tid 0 writes 0xA5A5A5A5 to entry 1 with lock_set=1, then writes 0 to entry 1 → first ack err=0, second err=1; a subsequent read returns 0xA5A5A5A5; viol_count increments by 1.
- CNT_WIDTH=2: 5 denied requests → viol_count sequence 1, 2, 3, 3, 3. Then viol_clr with a concurrent denial → viol_count=1, viol_sticky=1. Then viol_clr alone → viol_count=0, viol_sticky=0.
- NUM_REGS=6 and a locked entry present: tid 0 reads addr 7 → err=1, rdata=0. Assert rst_n low in the cycle after a write request → no ack, entries = RESET_VAL, all locks cleared, so a write to the formerly locked entry is granted.

Source files
------------

// File: rtl/secure_regfile.sv
// Owner-thread-gated register file with per-entry write locks and a saturating violation counter.
// Latency: one cycle, with ack/err/rdata registered. No backpressure: one request is accepted every cycle req_i=1.
module secure_regfile #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter int unsigned               NUM_REGS   = 8,
  parameter int unsigned               TID_WIDTH  = 4,
  parameter int unsigned               OWNER_TID  = 0,
  parameter int unsigned               CNT_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]     RESET_VAL  = '0,
  localparam int unsigned              AW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic                  lock_set_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [TID_WIDTH-1:0]  thread_id_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  viol_clr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  viol_count_o,
  output logic                  viol_sticky_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   lock_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, err_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_base;
  logic                  sticky_q, sticky_d;

  logic addr_ok, tid_ok, locked, grant, deny;

  // Out-of-range addresses only exist when NUM_REGS is not a power of two.
  if (NUM_REGS == (1 << AW)) begin : g_pow2
    assign addr_ok = 1'b1;
  end else begin : g_npow2
    assign addr_ok = (addr_i < AW'(NUM_REGS));
  end

  assign tid_ok = (thread_id_i == TID_WIDTH'(OWNER_TID));
  assign locked = addr_ok && lock_q[addr_i];
  assign grant  = req_i && tid_ok && addr_ok && !(we_i && locked);
  assign deny   = req_i && !grant;

  always_comb begin
    rdata_d = '0;
    if (grant && !we_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  // Clear takes effect before a same-cycle denial is counted.
  always_comb begin
    cnt_base = viol_clr_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (deny && (cnt_base != '1)) begin
      cnt_d = cnt_base + CNT_WIDTH'(1);
    end
    sticky_d = (viol_clr_i ? 1'b0 : sticky_q) | deny;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= RESET_VAL;
      end
      lock_q   <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      ack_q    <= req_i;
      err_q    <= deny;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      if (grant && we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      if (grant && lock_set_i) begin
        lock_q[addr_i] <= 1'b1;
      end
    end
  end

  assign rdata_o       = rdata_q;
  assign ack_o         = ack_q;
  assign err_o         = err_q;
  assign viol_count_o  = cnt_q;
  assign viol_sticky_o = sticky_q;

endmodule

// File: tb/tb_secure_regfile.sv
// Bench for secure_regfile: two instances (8 regs/8-bit counter, 6 regs/2-bit counter) share stimulus.
// A directed table, hand sequences and random traffic are checked against an array-based model.
module tb_secure_regfile;

  localparam logic [31:0] RV_B = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, we, lock_set, viol_clr;
  logic [2:0]  addr;
  logic [3:0]  tid;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b, st_a, st_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  secure_regfile #(.DATA_WIDTH(32), .NUM_REGS(8), .TID_WIDTH(4), .OWNER_TID(0),
                   .CNT_WIDTH(8), .RESET_VAL(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .lock_set_i(lock_set),
    .addr_i(addr), .thread_id_i(tid), .wdata_i(wdata), .viol_clr_i(viol_clr),
    .rdata_o(rdata_a), .ack_o(ack_a), .err_o(err_a),
    .viol_count_o(cnt_a), .viol_sticky_o(st_a));

  secure_regfile #(.DATA_WIDTH(32), .NUM_REGS(6), .TID_WIDTH(4), .OWNER_TID(0),
                   .CNT_WIDTH(2), .RESET_VAL(RV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .lock_set_i(lock_set),
    .addr_i(addr), .thread_id_i(tid), .wdata_i(wdata), .viol_clr_i(viol_clr),
    .rdata_o(rdata_b), .ack_o(ack_b), .err_o(err_b),
    .viol_count_o(cnt_b), .viol_sticky_o(st_b));

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  logic [31:0] mem_m  [2][8];
  bit          lock_m [2][8];
  int          cnt_m  [2];
  bit          st_m   [2];
  int          nregs  [2] = '{8, 6};
  int          cmax   [2] = '{255, 3};
  logic [31:0] rv     [2] = '{32'h0, RV_B};
  bit          e_ack  [2];
  bit          e_err  [2];
  logic [31:0] e_rd   [2];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rq, w, l;
    logic [2:0]  ad;
    logic [3:0]  t;
    logic [31:0] wd;
    logic        clr;
    logic        x_ack, x_err;
    logic [31:0] x_rd;
    int          x_cnt;
    logic        x_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rq, logic w, logic l, int ad, int t, logic [31:0] wd,
                              logic clr, logic xa, logic xe, logic [31:0] xr, int xc, logic xs);
    vec_t v;
    v.rq = rq; v.w = w; v.l = l; v.ad = 3'(ad); v.t = 4'(t); v.wd = wd; v.clr = clr;
    v.x_ack = xa; v.x_err = xe; v.x_rd = xr; v.x_cnt = xc; v.x_st = xs;
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        mem_m[d][i]  = rv[d];
        lock_m[d][i] = 1'b0;
      end
      cnt_m[d] = 0; st_m[d] = 1'b0;
      e_ack[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = '0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int c;
      bit s, deny;
      c = viol_clr ? 0 : cnt_m[d];
      s = viol_clr ? 1'b0 : st_m[d];
      e_ack[d] = req; e_err[d] = 1'b0; e_rd[d] = '0;
      if (req) begin
        deny = (tid != 4'd0) || (int'(addr) >= nregs[d]) || (we && lock_m[d][addr]);
        e_err[d] = deny;
        if (!deny) begin
          if (!we) e_rd[d] = mem_m[d][addr];
          else     mem_m[d][addr] = wdata;
          if (lock_set) lock_m[d][addr] = 1'b1;
        end else begin
          if (c < cmax[d]) c++;
          s = 1'b1;
        end
      end
      cnt_m[d] = c; st_m[d] = s;
    end
  endtask

  task automatic check_dut(input int d, input string tag);
    logic a, e, s;
    logic [31:0] r, c;
    if (d == 0) begin a = ack_a; e = err_a; r = rdata_a; c = 32'(cnt_a); s = st_a; end
    else        begin a = ack_b; e = err_b; r = rdata_b; c = 32'(cnt_b); s = st_b; end
    n_vec++;
    if (a !== e_ack[d] || e !== e_err[d] || r !== e_rd[d] || c !== 32'(cnt_m[d]) || s !== st_m[d]) begin
      n_bad++;
      $display("FAIL %s dut%0d: got ack=%b err=%b rdata=%h cnt=%0d sticky=%b, want ack=%b err=%b rdata=%h cnt=%0d sticky=%b",
               tag, d, a, e, r, c, s, e_ack[d], e_err[d], e_rd[d], cnt_m[d], st_m[d]);
    end
  endtask

  task automatic cycle(input logic rq, input logic w, input logic l, input logic [2:0] ad,
                       input logic [3:0] t, input logic [31:0] wd, input logic clr, input string tag);
    req = rq; we = w; lock_set = l; addr = ad; tid = t; wdata = wd; viol_clr = clr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    rst_n = 1'b0; req = 0; we = 0; lock_set = 0; viol_clr = 0; addr = '0; tid = '0; wdata = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_dut(0, "reset_state");
    check_dut(1, "reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, i, 0, 0, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 3, 0, 32'hDEADBEEF, 0, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 3, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 32'h0,        0, 1, 1, 32'h0,        1, 1));
    tbl.push_back(mk(1, 1, 0, 3, 5, 32'h1234,     0, 1, 1, 32'h0,        2, 1));
    tbl.push_back(mk(1, 0, 0, 3, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 2, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 32'hA5A5A5A5, 0, 1, 0, 32'h0,        2, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,        0, 1, 1, 32'h0,        3, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 32'h0,        0, 1, 0, 32'hA5A5A5A5, 3, 1));
    tbl.push_back(mk(1, 0, 1, 3, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 3, 1));
    tbl.push_back(mk(1, 0, 1, 3, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 3, 1));
    tbl.push_back(mk(1, 1, 0, 3, 0, 32'h7777,     0, 1, 1, 32'h0,        4, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0, 32'hFFFF,     0, 0, 0, 32'h0,        4, 1));
    tbl.push_back(mk(1, 0, 0, 2, 0, 32'h0,        0, 1, 0, 32'h0,        4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 7, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9, 32'h0,        1, 1, 1, 32'h0,        1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rq, tbl[i].w, tbl[i].l, tbl[i].ad, tbl[i].t, tbl[i].wd, tbl[i].clr, $sformatf("tbl%0d", i));
      n_vec++;
      if (ack_a !== tbl[i].x_ack || err_a !== tbl[i].x_err || rdata_a !== tbl[i].x_rd ||
          32'(cnt_a) !== 32'(tbl[i].x_cnt) || st_a !== tbl[i].x_st) begin
        n_bad++;
        $display("FAIL table%0d: got ack=%b err=%b rdata=%h cnt=%0d sticky=%b, want ack=%b err=%b rdata=%h cnt=%0d sticky=%b",
                 i, ack_a, err_a, rdata_a, cnt_a, st_a, tbl[i].x_ack, tbl[i].x_err, tbl[i].x_rd, tbl[i].x_cnt, tbl[i].x_st);
      end
    end

    // Two-bit counter saturation and clear ordering on dut_b.
    cycle(0, 0, 0, 0, 0, 0, 1, "sat_clr0");
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 0, 0, 7, 0, 0, $sformatf("sat%0d", k));
      expect_val($sformatf("sat_cnt%0d", k), 32'(cnt_b), 32'(sat_exp[k]));
    end
    cycle(1, 0, 0, 0, 7, 0, 1, "clr_with_deny");
    expect_val("clr_deny_cnt", 32'(cnt_b), 32'd1);
    expect_val("clr_deny_sticky", 32'(st_b), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 1, "clr_alone");
    expect_val("clr_cnt", 32'(cnt_b), 32'd0);
    expect_val("clr_sticky", 32'(st_b), 32'd0);

    cycle(1, 0, 0, 7, 0, 0, 0, "oob_read");
    expect_val("oob_err", 32'(err_b), 32'd1);
    expect_val("oob_rdata", rdata_b, 32'h0);

    // Reset lands while the ack of a write is being presented.
    req = 1; we = 1; lock_set = 0; addr = 3'd0; tid = 4'd0; wdata = 32'hCAFEF00D; viol_clr = 0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_dut(0, "midreset");
    check_dut(1, "midreset");
    @(negedge clk);
    check_dut(0, "reset_held");
    check_dut(1, "reset_held");
    rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0, 0, 0, "post_reset_rd0");
    expect_val("post_reset_rv", rdata_b, RV_B);
    cycle(1, 1, 0, 1, 0, 32'h11112222, 0, "unlocked_after_reset");
    expect_val("unlocked_err", 32'(err_b), 32'd0);
    cycle(1, 0, 0, 1, 0, 0, 0, "readback1");
    expect_val("readback1_val", rdata_b, 32'h11112222);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #1 model_reset();
        check_dut(0, "rand_reset");
        check_dut(1, "rand_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle(($urandom_range(0, 9) < 8), $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
            3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
            $urandom, ($urandom_range(0, 19) == 0), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
